// File: rtl/iquan_pkg.sv
// Shared types, default widths and saturation helpers for the inverse-quantisation engine.
package iquan_pkg;

    localparam int QW_DEF        = 4;
    localparam int OW_DEF        = 16;
    localparam int FRAME_LEN_DEF = 256;
    localparam int NCH_DEF       = 2;
    localparam int SHW_DEF       = 4;
    localparam int RD_LAT_DEF    = 1;
    localparam int SAT_CNT_W     = 16;

    // Frame controller state encoding.
    typedef logic [1:0] iq_state_t;
    localparam iq_state_t ST_IDLE  = 2'd0;
    localparam iq_state_t ST_RUN   = 2'd1;
    localparam iq_state_t ST_DRAIN = 2'd2;
    localparam iq_state_t ST_DONE  = 2'd3;

    // Largest value representable in an ow-bit two's complement sample.
    function automatic logic signed [63:0] sat_max(input int ow);
        return (64'sd1 <<< (ow - 1)) - 64'sd1;
    endfunction

    // Smallest value representable in an ow-bit two's complement sample.
    function automatic logic signed [63:0] sat_min(input int ow);
        return -(64'sd1 <<< (ow - 1));
    endfunction

    // Clamp a wide signed value into the ow-bit range; sat reports that clipping happened.
    function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                     input int ow,
                                                     output logic sat);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] r;
        hi  = sat_max(ow);
        lo  = sat_min(ow);
        r   = v;
        sat = 1'b0;
        if (v > hi) begin
            r   = hi;
            sat = 1'b1;
        end else if (v < lo) begin
            r   = lo;
            sat = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/iquan_dequant.sv
// Combinational dequantiser: sign-extend, power-of-two rescale, saturate, optional offset binary.
module iquan_dequant
    import iquan_pkg::*;
#(
    parameter int QW  = QW_DEF,
    parameter int OW  = OW_DEF,
    parameter int SHW = SHW_DEF
) (
    input  logic [QW-1:0]  q_i,
    input  logic [SHW-1:0] shift_i,
    input  logic           offset_bin_i,
    output logic [OW-1:0]  y_o,
    output logic           sat_o
);

    // Wide enough that the largest shift of the most negative code never overflows.
    localparam int VW = QW + (2 ** SHW) - 1;

    logic signed [VW-1:0] q_ext;
    logic signed [VW-1:0] v;
    logic signed [63:0]   v_wide;
    logic [OW-1:0]        y;
    logic                 sat;

    // Rescale and clip one code; the MSB flip turns two's complement into offset binary.
    always_comb begin
        q_ext  = {{(VW - QW){q_i[QW-1]}}, q_i};
        v      = q_ext <<< shift_i;
        v_wide = {{(64 - VW){v[VW-1]}}, v};
        sat    = 1'b0;
        y      = OW'(sat_clamp(v_wide, OW, sat));
        if (offset_bin_i) begin
            y[OW-1] = ~y[OW-1];
        end
        y_o   = y;
        sat_o = sat;
    end

endmodule

// File: rtl/iquan_frame_engine.sv
// Frame controller: walks the source RAM once per start, dequantises each code and writes PCM.
module iquan_frame_engine
    import iquan_pkg::*;
#(
    parameter int QW        = QW_DEF,
    parameter int OW        = OW_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int NCH       = NCH_DEF,
    parameter int SHW       = SHW_DEF,
    parameter int RD_LAT    = RD_LAT_DEF,
    parameter int AW        = $clog2(FRAME_LEN * NCH)
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               offset_bin,
    input  logic [NCH*SHW-1:0] shift_cfg,
    input  logic               intr_clr,
    output logic               busy,
    output logic               intr,
    output logic [15:0]        sat_cnt,
    output logic [AW-1:0]      rd_addr,
    output logic               rd_en,
    input  logic [QW-1:0]      rd_data,
    output logic [AW-1:0]      wr_addr,
    output logic               wr_en,
    output logic [OW-1:0]      wr_data
);

    localparam int N   = FRAME_LEN * NCH;
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    // Control state
    iq_state_t            state_q, state_d;
    logic [AW-1:0]        rd_addr_q, rd_addr_d;
    logic [CHW-1:0]       ch_q, ch_d;
    logic [NCH*SHW-1:0]   shift_q, shift_d;
    logic                 offset_q, offset_d;
    logic                 intr_q, intr_d;
    logic [SAT_CNT_W-1:0] sat_cnt_q, sat_cnt_d;

    // Read-latency alignment pipe: valid is reset, the payload it qualifies is not.
    logic [RD_LAT-1:0]    vld_q;
    logic [AW-1:0]        addr_pipe_q [RD_LAT];
    logic [CHW-1:0]       ch_pipe_q   [RD_LAT];

    // Write stage
    logic                 wr_en_q;
    logic [AW-1:0]        wr_addr_q;
    logic [OW-1:0]        wr_data_q;

    logic                 start_acc;
    logic                 flush;
    logic                 last_rd;
    logic                 pipe_empty;
    logic                 vld_last;
    logic [SHW-1:0]       cur_shift;
    logic [OW-1:0]        deq_y;
    logic                 deq_sat;

    assign start_acc  = start && (state_q == ST_IDLE);
    assign flush      = abort && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
    assign last_rd    = (state_q == ST_RUN) && (rd_addr_q == AW'(N - 1));
    assign pipe_empty = (vld_q == '0);
    assign vld_last   = vld_q[RD_LAT-1];
    assign cur_shift  = shift_q[ch_pipe_q[RD_LAT-1]*SHW +: SHW];

    iquan_dequant #(
        .QW  (QW),
        .OW  (OW),
        .SHW (SHW)
    ) u_dequant (
        .q_i          (rd_data),
        .shift_i      (cur_shift),
        .offset_bin_i (offset_q),
        .y_o          (deq_y),
        .sat_o        (deq_sat)
    );

    // Next-state logic for the frame FSM, read counters, config capture, interrupt and sat count.
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        ch_d      = ch_q;
        shift_d   = shift_q;
        offset_d  = offset_q;
        intr_d    = intr_q;
        sat_cnt_d = sat_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    rd_addr_d = '0;
                    ch_d      = '0;
                    shift_d   = shift_cfg;
                    offset_d  = offset_bin;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (last_rd) begin
                    state_d = ST_DRAIN;
                end else begin
                    rd_addr_d = rd_addr_q + AW'(1);
                    // Channel walks alongside the address so no modulo is needed.
                    ch_d      = (ch_q == CHW'(NCH - 1)) ? '0 : ch_q + CHW'(1);
                end
            end
            ST_DRAIN: begin
                // Empty valid pipe means the write stage holds the last sample this cycle.
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (pipe_empty) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_acc || intr_clr) begin
            intr_d = 1'b0;
        end else if ((state_q == ST_DRAIN) && !abort && pipe_empty) begin
            intr_d = 1'b1;
        end

        // Count in the cycle before the write so aborted (never written) samples are not counted.
        if (start_acc) begin
            sat_cnt_d = '0;
        end else if (vld_last && !flush && deq_sat && (sat_cnt_q != '1)) begin
            sat_cnt_d = sat_cnt_q + SAT_CNT_W'(1);
        end
    end

    // Control registers.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rd_addr_q <= '0;
            ch_q      <= '0;
            shift_q   <= '0;
            offset_q  <= 1'b0;
            intr_q    <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            ch_q      <= ch_d;
            shift_q   <= shift_d;
            offset_q  <= offset_d;
            intr_q    <= intr_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    // Valid pipe and write stage; abort empties both so strobes drop on the next cycle.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            vld_q[0] <= rd_en && !flush;
            for (int k = 1; k < RD_LAT; k++) begin
                vld_q[k] <= vld_q[k-1] && !flush;
            end
            wr_en_q <= vld_last && !flush;
            if (vld_last) begin
                wr_addr_q <= addr_pipe_q[RD_LAT-1];
                wr_data_q <= deq_y;
            end
        end
    end

    // Address and channel travel with the read; qualified by vld_q, so no reset needed.
    always_ff @(posedge clk_in) begin
        addr_pipe_q[0] <= rd_addr_q;
        ch_pipe_q[0]   <= ch_q;
        for (int k = 1; k < RD_LAT; k++) begin
            addr_pipe_q[k] <= addr_pipe_q[k-1];
            ch_pipe_q[k]   <= ch_pipe_q[k-1];
        end
    end

    assign busy    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign intr    = intr_q;
    assign sat_cnt = sat_cnt_q;
    assign rd_en   = (state_q == ST_RUN);
    assign rd_addr = rd_addr_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_iquan_frame_engine.sv
// Bench for iquan_frame_engine: two instances (read latency 1 and 3) share one stimulus stream.
module tb_iquan_frame_engine;

    localparam int N   = 512;
    localparam int CAP = 16384;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        offset_bin;
    logic [7:0]  shift_cfg;
    logic        intr_clr;

    logic        busy_s    [2];
    logic        intr_s    [2];
    logic [15:0] sat_cnt_s [2];
    logic [8:0]  rd_addr_s [2];
    logic        rd_en_s   [2];
    logic [3:0]  rd_data_s [2];
    logic [8:0]  wr_addr_s [2];
    logic        wr_en_s   [2];
    logic [15:0] wr_data_s [2];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [3:0]  mem [N];
    logic [3:0]  r1_q;
    logic [3:0]  r3_q [3];

    logic [8:0]  cap_addr [2][CAP];
    logic [15:0] cap_data [2][CAP];
    int          cap_cyc  [2][CAP];
    int          cap_n     [2];
    int          intr_rise [2];
    int          busy_fall [2];
    bit          intr_prev [2];
    bit          busy_prev [2];

    typedef struct {
        logic [3:0] qe;
        logic [3:0] qo;
        int         sh0;
        int         sh1;
        bit         offb;
        int         exp_e;
        int         exp_o;
        int         exp_sat;
    } vec_t;

    vec_t tab [8];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    iquan_frame_engine #(
        .QW(4), .OW(16), .FRAME_LEN(256), .NCH(2), .SHW(4), .RD_LAT(1), .AW(9)
    ) u_dut_l1 (
        .clk_in(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .offset_bin(offset_bin), .shift_cfg(shift_cfg), .intr_clr(intr_clr),
        .busy(busy_s[0]), .intr(intr_s[0]), .sat_cnt(sat_cnt_s[0]),
        .rd_addr(rd_addr_s[0]), .rd_en(rd_en_s[0]), .rd_data(rd_data_s[0]),
        .wr_addr(wr_addr_s[0]), .wr_en(wr_en_s[0]), .wr_data(wr_data_s[0])
    );

    iquan_frame_engine #(
        .QW(4), .OW(16), .FRAME_LEN(256), .NCH(2), .SHW(4), .RD_LAT(3), .AW(9)
    ) u_dut_l3 (
        .clk_in(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .offset_bin(offset_bin), .shift_cfg(shift_cfg), .intr_clr(intr_clr),
        .busy(busy_s[1]), .intr(intr_s[1]), .sat_cnt(sat_cnt_s[1]),
        .rd_addr(rd_addr_s[1]), .rd_en(rd_en_s[1]), .rd_data(rd_data_s[1]),
        .wr_addr(wr_addr_s[1]), .wr_en(wr_en_s[1]), .wr_data(wr_data_s[1])
    );

    // Source RAM models with 1 and 3 cycles of read latency.
    always @(posedge clk) begin
        r1_q    <= mem[rd_addr_s[0]];
        r3_q[0] <= mem[rd_addr_s[1]];
        r3_q[1] <= r3_q[0];
        r3_q[2] <= r3_q[1];
    end
    assign rd_data_s[0] = r1_q;
    assign rd_data_s[1] = r3_q[2];

    // Write capture and edge timestamps, sampled on the falling edge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (wr_en_s[d] === 1'b1 && cap_n[d] < CAP) begin
                cap_addr[d][cap_n[d]] <= wr_addr_s[d];
                cap_data[d][cap_n[d]] <= wr_data_s[d];
                cap_cyc[d][cap_n[d]]  <= cyc;
                cap_n[d]              <= cap_n[d] + 1;
            end
            if (intr_s[d] === 1'b1 && !intr_prev[d]) intr_rise[d] <= cyc;
            if (busy_s[d] === 1'b0 && busy_prev[d])  busy_fall[d] <= cyc;
            intr_prev[d] <= (intr_s[d] === 1'b1);
            busy_prev[d] <= (busy_s[d] === 1'b1);
        end
    end

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Reference dequantiser: integer rescale, clip to 16-bit signed, optional MSB flip.
    function automatic int ref_sample(input logic [3:0] code, input int sh, input bit offb,
                                      output bit sat);
        longint q;
        longint v;
        int     r;
        q   = (code >= 4'd8) ? longint'(code) - 16 : longint'(code);
        v   = q * (longint'(1) << sh);
        sat = 1'b0;
        if (v > 32767) begin
            v   = 32767;
            sat = 1'b1;
        end else if (v < -32768) begin
            v   = -32768;
            sat = 1'b1;
        end
        r = int'(v) & 32'hFFFF;
        if (offb) r = r ^ 32'h8000;
        return r;
    endfunction

    function automatic longint outs_packed(input int d);
        return longint'({busy_s[d], intr_s[d], rd_en_s[d], wr_en_s[d], sat_cnt_s[d],
                         rd_addr_s[d], wr_addr_s[d], wr_data_s[d]});
    endfunction

    // Called on a falling edge; pulses start for one cycle and returns the start cycle.
    task automatic do_start(input int sh0, input int sh1, input bit offb, input bit clr,
                            output int s);
        shift_cfg  = {sh1[3:0], sh0[3:0]};
        offset_bin = offb;
        intr_clr   = clr;
        start      = 1'b1;
        s          = cyc;
        @(negedge clk);
        start      = 1'b0;
        intr_clr   = 1'b0;
        offset_bin = ~offb;
        shift_cfg  = ~shift_cfg;
    endtask

    task automatic run_frame(input string nm, input int sh0, input int sh1, input bit offb,
                             input bit clr, input bit use_tab, input int te, input int to,
                             input int tsat, input bit poke);
        int s;
        int base [2];
        for (int d = 0; d < 2; d++) base[d] = cap_n[d];
        do_start(sh0, sh1, offb, clr, s);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_busy_after_start[%0d]", nm, d), busy_s[d], 1);
            check($sformatf("%s_intr_after_start[%0d]", nm, d), intr_s[d], 0);
        end
        for (int i = 0; i < N + 12; i++) begin
            if (poke && (i == 40 || i == 300 || i == 505)) begin
                start     = 1'b1;
                shift_cfg = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        for (int d = 0; d < 2; d++) begin
            int lat;
            int nwr;
            int mism;
            int esat;
            int expd;
            int firstc;
            bit sflag;
            lat  = (d == 0) ? 1 : 3;
            nwr  = cap_n[d] - base[d];
            mism = 0;
            esat = 0;
            for (int a = 0; a < N; a++) begin
                if (use_tab) begin
                    expd = (a % 2 == 1) ? to : te;
                end else begin
                    expd = ref_sample(mem[a], (a % 2 == 1) ? sh1 : sh0, offb, sflag);
                    if (sflag) esat++;
                end
                if (a < nwr) begin
                    if (int'(cap_addr[d][base[d]+a]) != a || int'(cap_data[d][base[d]+a]) != expd)
                        mism++;
                end
            end
            if (use_tab) esat = tsat;
            firstc = (nwr > 0) ? cap_cyc[d][base[d]] : -1;
            check($sformatf("%s_writes[L%0d]", nm, lat), nwr, N);
            check($sformatf("%s_data_mismatches[L%0d]", nm, lat), mism, 0);
            check($sformatf("%s_first_wr_cycle[L%0d]", nm, lat), firstc - s, lat + 2);
            check($sformatf("%s_intr_cycle[L%0d]", nm, lat), intr_rise[d] - s, N + lat + 2);
            check($sformatf("%s_busy_fall_cycle[L%0d]", nm, lat), busy_fall[d] - s, N + lat + 2);
            check($sformatf("%s_sat_cnt[L%0d]", nm, lat), sat_cnt_s[d], esat);
            check($sformatf("%s_intr_end[L%0d]", nm, lat), intr_s[d], 1);
        end
    endtask

    initial begin
        int s;
        int base [2];
        int sh0;
        int sh1;
        bit offb;

        tab[0] = '{4'h7, 4'h8, 12, 3,  1'b0, 'h7000, 'hFFC0, 0};
        tab[1] = '{4'h7, 4'h7, 13, 3,  1'b0, 'h7FFF, 'h0038, 256};
        tab[2] = '{4'h8, 4'h8, 13, 3,  1'b0, 'h8000, 'hFFC0, 256};
        tab[3] = '{4'h0, 4'hF, 0,  0,  1'b1, 'h8000, 'h7FFF, 0};
        tab[4] = '{4'h7, 4'h8, 15, 15, 1'b0, 'h7FFF, 'h8000, 512};
        tab[5] = '{4'h8, 4'hF, 12, 15, 1'b0, 'h8000, 'h8000, 0};
        tab[6] = '{4'h1, 4'h1, 15, 14, 1'b1, 'hFFFF, 'hC000, 256};
        tab[7] = '{4'hF, 4'h3, 0,  0,  1'b0, 'hFFFF, 'h0003, 0};

        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        offset_bin = 1'b0;
        shift_cfg  = '0;
        intr_clr   = 1'b0;
        for (int a = 0; a < N; a++) mem[a] = '0;

        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) check($sformatf("reset_outputs[%0d]", d), outs_packed(d), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Ramp codes, unity scale: output is the sign-extended code.
        for (int a = 0; a < N; a++) mem[a] = 4'(a);
        run_frame("ramp", 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);

        // Table of constant-code frames with hand-computed outputs.
        for (int v = 0; v < 8; v++) begin
            for (int a = 0; a < N; a++) mem[a] = (a % 2 == 1) ? tab[v].qo : tab[v].qe;
            run_frame($sformatf("tab%0d", v), tab[v].sh0, tab[v].sh1, tab[v].offb, 1'b0,
                      1'b1, tab[v].exp_e, tab[v].exp_o, tab[v].exp_sat, 1'b0);
        end

        // Random codes and configuration against the reference model.
        for (int r = 0; r < 3; r++) begin
            for (int a = 0; a < N; a++) mem[a] = 4'($urandom);
            sh0  = int'($urandom_range(0, 15));
            sh1  = int'($urandom_range(0, 15));
            offb = 1'($urandom);
            run_frame($sformatf("rand%0d", r), sh0, sh1, offb, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        end

        // intr is sticky until intr_clr.
        repeat (5) @(negedge clk);
        for (int d = 0; d < 2; d++) check($sformatf("intr_sticky[%0d]", d), intr_s[d], 1);
        intr_clr = 1'b1;
        @(negedge clk);
        intr_clr = 1'b0;
        for (int d = 0; d < 2; d++) check($sformatf("intr_clr[%0d]", d), intr_s[d], 0);

        // Set intr again, then start with intr_clr and stray start pulses during RUN.
        for (int a = 0; a < N; a++) mem[a] = 4'($urandom);
        run_frame("pre_clr", 5, 9, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        for (int a = 0; a < N; a++) mem[a] = 4'(a);
        run_frame("clr_start_poke", 2, 7, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b1);

        // Abort while read 100 is on the bus; every sample saturates.
        for (int a = 0; a < N; a++) mem[a] = (a % 2 == 1) ? 4'h8 : 4'h7;
        for (int d = 0; d < 2; d++) base[d] = cap_n[d];
        do_start(15, 15, 1'b0, 1'b0, s);
        for (int i = 0; i < 300 && !(rd_en_s[0] && rd_addr_s[0] == 9'd100); i++) @(negedge clk);
        check("abort_reached_read100", rd_addr_s[0], 100);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("abort_rd_en[%0d]", d), rd_en_s[d], 0);
            check($sformatf("abort_wr_en[%0d]", d), wr_en_s[d], 0);
            check($sformatf("abort_busy[%0d]", d), busy_s[d], 0);
        end
        repeat (10) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            int lat;
            lat = (d == 0) ? 1 : 3;
            check($sformatf("abort_writes[L%0d]", lat), cap_n[d] - base[d], 100 - lat);
            check($sformatf("abort_intr[L%0d]", lat), intr_s[d], 0);
            check($sformatf("abort_sat_kept[L%0d]", lat), sat_cnt_s[d], 100 - lat);
        end
        run_frame("after_abort", 15, 15, 1'b0, 1'b0, 1'b1, 'h7FFF, 'h8000, 512, 1'b0);

        // Asynchronous reset in the middle of DRAIN.
        for (int a = 0; a < N; a++) mem[a] = 4'($urandom);
        do_start(4, 11, 1'b0, 1'b0, s);
        for (int i = 0; i < N + 10 && cyc < s + N + 2; i++) @(negedge clk);
        check("drain_cycle_reached", cyc - s, N + 2);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("drain_busy[%0d]", d), busy_s[d], 1);
            check($sformatf("drain_rd_en[%0d]", d), rd_en_s[d], 0);
        end
        check("drain_last_write_L1", wr_en_s[0], 1);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("async_reset_outputs[%0d]", d), outs_packed(d), 0);
            base[d] = cap_n[d];
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("post_reset_no_write[%0d]", d), cap_n[d] - base[d], 0);
            check($sformatf("post_reset_idle[%0d]", d), outs_packed(d), 0);
        end

        // Recovery frame after reset.
        for (int a = 0; a < N; a++) mem[a] = 4'($urandom);
        run_frame("recover", 9, 1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
